// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with LSB-first/MSB-first assembly,
// a one-entry output holding register, overrun flag and frame realignment.
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             start,
  output logic [WIDTH-1:0] Pout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [7:0]       word_cnt
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bcnt;
  logic             dir_q;

  logic [WIDTH-1:0] base_shreg;
  logic [BW-1:0]    base_bcnt;
  logic             cur_dir;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             load;
  logic             drop;

  // Handshake: a word transfers on any edge where out_valid and out_ready
  // are both high; a completed word may load into Pout on that same edge,
  // otherwise it loads only when the holding register is empty.
  always_comb begin
    base_shreg = start ? '0 : shreg;
    base_bcnt  = start ? '0 : bcnt;
    cur_dir    = (base_bcnt == '0) ? dir : dir_q;
    shifted    = cur_dir ? {base_shreg[WIDTH-2:0], Sin}
                         : {Sin, base_shreg[WIDTH-1:1]};
    // start zeroes the bit count, so it can never complete a word itself
    complete   = sin_valid && (base_bcnt == LAST);
    load       = complete && (!out_valid || out_ready);
    drop       = complete && !load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bcnt      <= '0;
      dir_q     <= 1'b0;
      Pout      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      word_cnt  <= 8'd0;
    end else begin
      if (sin_valid) begin
        shreg <= shifted;
        bcnt  <= complete ? '0 : base_bcnt + BW'(1);
        dir_q <= cur_dir;
      end else begin
        shreg <= base_shreg;
        bcnt  <= base_bcnt;
      end

      if (load) begin
        Pout     <= shifted;
        word_cnt <= word_cnt + 8'd1;
      end
      out_valid <= load || (out_valid && !out_ready);

      if (drop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed test-plan scenarios plus random
// traffic checked against a bit-queue reference model.
module tb_serial_word_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         dir = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] pout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         overrun;
  logic         clr_overrun = 1'b0;
  logic [7:0]   word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit         m_bits[$];
  bit         m_dir;
  logic [W-1:0] m_pout;
  bit         m_valid;
  bit         m_ovr;
  logic [7:0] m_cnt;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Sin(sin), .sin_valid(sin_valid), .dir(dir),
    .start(start), .Pout(pout), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .clr_overrun(clr_overrun), .word_cnt(word_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: bits are collected in arrival order; word[i] = i-th bit when
  // LSB-first, word[W-1-i] = i-th bit when MSB-first
  task automatic model_edge();
    logic [W-1:0] word;
    bit consume, loaded, dropped;
    if (rst) begin
      m_bits.delete();
      m_dir = 0; m_pout = '0; m_valid = 0; m_ovr = 0; m_cnt = 8'd0;
      return;
    end
    consume = m_valid && out_ready;
    loaded = 0; dropped = 0;
    if (start) m_bits.delete();
    if (sin_valid) begin
      if (m_bits.size() == 0) m_dir = dir;
      m_bits.push_back(sin);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++)
          if (m_dir) word[W-1-i] = m_bits[i];
          else       word[i] = m_bits[i];
        m_bits.delete();
        if (!m_valid || consume) begin
          m_pout = word; loaded = 1; m_cnt = m_cnt + 8'd1;
        end else dropped = 1;
      end
    end
    if (loaded) m_valid = 1;
    else if (consume) m_valid = 0;
    if (dropped) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
  endtask

  // driver: apply inputs, advance one edge, sample 1ns later
  task automatic drive(input logic r, input logic st, input logic sv,
                       input logic s, input logic d, input logic rdy,
                       input logic clr);
    rst = r; start = st; sin_valid = sv; sin = s; dir = d;
    out_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; start = 0; sin_valid = 0; clr_overrun = 0;
  endtask

  task automatic send_bit(input logic s, input logic d, input logic rdy);
    drive(0, 0, 1, s, d, rdy, 0);
  endtask

  task automatic send_word_lsb(input logic [W-1:0] w, input logic rdy);
    for (int i = 0; i < W; i++) send_bit(w[i], 1'b0, rdy);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({pout, out_valid, overrun, word_cnt} !== {{W{1'b0}}, 1'b0, 1'b0, 8'd0})
      $display("FAIL reset: got pout=%h v=%b ovr=%b cnt=%0d, want all zero",
               pout, out_valid, overrun, word_cnt);
    else n_pass++;
  endtask

  task automatic test_lsb_first();
    drive(1, 0, 0, 0, 0, 1, 0);
    send_bit(1, 0, 1); send_bit(0, 0, 1); send_bit(1, 0, 1); send_bit(1, 0, 1);
    n_checks++;
    if (pout !== 4'hD || out_valid !== 1'b1 || word_cnt !== 8'd1)
      $display("FAIL lsb_first: got pout=%h v=%b cnt=%0d, want D 1 1",
               pout, out_valid, word_cnt);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL lsb_valid_drop: got v=%b, want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_msb_first();
    send_bit(1, 1, 1); send_bit(0, 1, 1); send_bit(1, 1, 1); send_bit(1, 1, 1);
    n_checks++;
    if (pout !== 4'hB || word_cnt !== 8'd2)
      $display("FAIL msb_first: got pout=%h cnt=%0d, want B 2", pout, word_cnt);
    else n_pass++;
    send_bit(1, 1, 1); send_bit(0, 0, 1); send_bit(1, 0, 1); send_bit(1, 0, 1);
    n_checks++;
    if (pout !== 4'hB || word_cnt !== 8'd3)
      $display("FAIL msb_dir_toggle: got pout=%h cnt=%0d, want B 3", pout, word_cnt);
    else n_pass++;
  endtask

  task automatic test_overrun();
    drive(1, 0, 0, 0, 0, 0, 0);
    send_word_lsb(4'h3, 0);
    send_word_lsb(4'h5, 0);
    n_checks++;
    if (pout !== 4'h3 || overrun !== 1'b1 || word_cnt !== 8'd1 || out_valid !== 1'b1)
      $display("FAIL overrun: got pout=%h ovr=%b cnt=%0d v=%b, want 3 1 1 1",
               pout, overrun, word_cnt, out_valid);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (overrun !== 1'b0)
      $display("FAIL clr_overrun: got ovr=%b, want 0", overrun);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if (out_valid !== 1'b0 || pout !== 4'h3)
      $display("FAIL overrun_drain: got v=%b pout=%h, want 0 3", out_valid, pout);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 0, 0, 0);
    send_word_lsb(4'h3, 0);
    send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(0, 0, 1);
    n_checks++;
    if (pout !== 4'h5 || out_valid !== 1'b1 || overrun !== 1'b0 || word_cnt !== 8'd2)
      $display("FAIL drain_on_load: got pout=%h v=%b ovr=%b cnt=%0d, want 5 1 0 2",
               pout, out_valid, overrun, word_cnt);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_realign();
    drive(1, 0, 0, 0, 0, 1, 0);
    send_bit(1, 0, 1); send_bit(1, 0, 1);
    drive(0, 1, 1, 0, 0, 1, 0);
    n_checks++;
    if (out_valid !== 1'b0 || word_cnt !== 8'd0)
      $display("FAIL realign_partial: got v=%b cnt=%0d, want 0 0", out_valid, word_cnt);
    else n_pass++;
    send_bit(0, 0, 1); send_bit(0, 0, 1); send_bit(1, 0, 1);
    n_checks++;
    if (pout !== 4'h8 || out_valid !== 1'b1 || word_cnt !== 8'd1)
      $display("FAIL realign: got pout=%h v=%b cnt=%0d, want 8 1 1",
               pout, out_valid, word_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    send_bit(1, 0, 1); send_bit(1, 0, 1);
    drive(1, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if ({pout, out_valid, overrun, word_cnt} !== {{W{1'b0}}, 1'b0, 1'b0, 8'd0})
      $display("FAIL reset_mid_word: got pout=%h v=%b ovr=%b cnt=%0d, want all zero",
               pout, out_valid, overrun, word_cnt);
    else n_pass++;
    send_bit(0, 0, 1); send_bit(1, 0, 1); send_bit(1, 0, 1); send_bit(0, 0, 1);
    n_checks++;
    if (pout !== 4'h6 || word_cnt !== 8'd1)
      $display("FAIL reset_fresh_word: got pout=%h cnt=%0d, want 6 1", pout, word_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic r, st, sv, s, d, rdy, clr;
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 29) == 0);
      sv  = ($urandom_range(0, 9) < 8);
      s   = 1'($urandom_range(0, 1));
      d   = ($urandom_range(0, 9) < 2) ? ~dir : dir;
      rdy = ($urandom_range(0, 9) < ((c / 250) % 2 ? 3 : 8));
      clr = ($urandom_range(0, 19) == 0);
      drive(r, st, sv, s, d, rdy, clr);
      dir = d;
      n_checks++;
      if (pout !== m_pout || out_valid !== m_valid || overrun !== m_ovr ||
          word_cnt !== m_cnt)
        $display("FAIL random cyc %0d: got pout=%h v=%b ovr=%b cnt=%0d, want %h %b %b %0d",
                 c, pout, out_valid, overrun, word_cnt, m_pout, m_valid, m_ovr, m_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_overrun();
    test_back_to_back();
    test_realign();
    test_reset_mid_word();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
